window_reader: RTL

Parametrised frame-buffer window reader for the 65 MHz VGA side of the camera pipeline. It maps the raster position (hcount/vcount) into a read address for a SRC_W x SRC_H frame buffer placed at a programmable screen offset, with power-of-two upscaling and horizontal mirror. It returns the BRAM pixel with hsync/vsync/blank delayed to match, zeroing pixels outside the window. Offset, scale and mirror are shadowed and take effect only at frame start, so changes never tear a frame.

---
 rtl/window_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/window_reader.sv
// Frame-buffer window reader: maps raster position to a BRAM address for a scaled,
// optionally mirrored SRC_W x SRC_H window, and returns the pixel with aligned raster controls.
module window_reader #(
   parameter int H_WIDTH        = 11,
   parameter int V_WIDTH        = 10,
   parameter int SRC_W          = 320,
   parameter int SRC_H          = 240,
   parameter int ADDR_WIDTH     = 17,
   parameter int PIX_WIDTH      = 11,
   parameter int BRAM_LATENCY   = 2,
   parameter int MAX_SCALE_LOG2 = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [H_WIDTH-1:0]    hcount_in,
   input  logic [V_WIDTH-1:0]    vcount_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  blank_in,
   input  logic [H_WIDTH-1:0]    x_off_in,
   input  logic [V_WIDTH-1:0]    y_off_in,
   input  logic [1:0]            scale_in,
   input  logic                  mirror_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [PIX_WIDTH-1:0]  pix_in,
   output logic [PIX_WIDTH-1:0]  pixel_out,
   output logic                  in_window_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  blank_out
);

   localparam int         LAT   = 3 + BRAM_LATENCY;
   localparam int         DLY   = LAT - 1;
   localparam logic [1:0] MAX_S = 2'(MAX_SCALE_LOG2);

   logic                 vsync_prev;
   logic [H_WIDTH-1:0]   cfg_x;
   logic [V_WIDTH-1:0]   cfg_y;
   logic [1:0]           cfg_scale;
   logic                 cfg_mirror;

   logic                 vsync_rise;
   logic [1:0]           scale_clamp;

   assign vsync_rise  = vsync_in & ~vsync_prev;
   assign scale_clamp = (scale_in > MAX_S) ? MAX_S : scale_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vsync_prev <= 1'b0;
         cfg_x      <= '0;
         cfg_y      <= '0;
         cfg_scale  <= '0;
         cfg_mirror <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         if (vsync_rise) begin
            cfg_x      <= x_off_in;
            cfg_y      <= y_off_in;
            cfg_scale  <= scale_clamp;
            cfg_mirror <= mirror_in;
         end
      end
   end

   // Stage 1: signed window-relative position, one extra bit so left/above is negative
   logic [H_WIDTH:0] rel_x_c;
   logic [V_WIDTH:0] rel_y_c;
   logic [31:0]      lim_x;
   logic [31:0]      lim_y;
   logic             win_c;

   always_comb begin
      rel_x_c = {1'b0, hcount_in} - {1'b0, cfg_x};
      rel_y_c = {1'b0, vcount_in} - {1'b0, cfg_y};
      lim_x   = 32'(SRC_W) << cfg_scale;
      lim_y   = 32'(SRC_H) << cfg_scale;
      win_c   = !rel_x_c[H_WIDTH] && (32'(rel_x_c) < lim_x) &&
                !rel_y_c[V_WIDTH] && (32'(rel_y_c) < lim_y);
   end

   logic [H_WIDTH-1:0] s1_rel_x;
   logic [V_WIDTH-1:0] s1_rel_y;
   logic [1:0]         s1_scale;
   logic               s1_mirror;

   // Flag pipeline bits: [3]=win [2]=hsync [1]=vsync [0]=blank
   logic [3:0] flag_pipe [DLY];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_rel_x  <= '0;
         s1_rel_y  <= '0;
         s1_scale  <= '0;
         s1_mirror <= 1'b0;
         for (int i = 0; i < DLY; i++) flag_pipe[i] <= '0;
      end else begin
         s1_rel_x     <= rel_x_c[H_WIDTH-1:0];
         s1_rel_y     <= rel_y_c[V_WIDTH-1:0];
         s1_scale     <= cfg_scale;
         s1_mirror    <= cfg_mirror;
         flag_pipe[0] <= {win_c, hsync_in, vsync_in, blank_in};
         for (int i = 1; i < DLY; i++) flag_pipe[i] <= flag_pipe[i-1];
      end
   end

   // Stage 2: downscale to source coordinates; address forced to 0 outside the window
   logic [H_WIDTH-1:0]    sx;
   logic [H_WIDTH-1:0]    sx_m;
   logic [V_WIDTH-1:0]    sy;
   logic [ADDR_WIDTH-1:0] addr_c;

   always_comb begin
      sx     = s1_rel_x >> s1_scale;
      sy     = s1_rel_y >> s1_scale;
      sx_m   = s1_mirror ? (H_WIDTH'(SRC_W - 1) - sx) : sx;
      addr_c = ADDR_WIDTH'(sy) * ADDR_WIDTH'(SRC_W) + ADDR_WIDTH'(sx_m);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         addr_out      <= '0;
         pixel_out     <= '0;
         in_window_out <= 1'b0;
         hsync_out     <= 1'b0;
         vsync_out     <= 1'b0;
         blank_out     <= 1'b0;
      end else begin
         addr_out      <= flag_pipe[0][3] ? addr_c : '0;
         pixel_out     <= (flag_pipe[DLY-1][3] && !flag_pipe[DLY-1][0]) ? pix_in : '0;
         in_window_out <= flag_pipe[DLY-1][3];
         hsync_out     <= flag_pipe[DLY-1][2];
         vsync_out     <= flag_pipe[DLY-1][1];
         blank_out     <= flag_pipe[DLY-1][0];
      end
   end

endmodule
